// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access codes, FSM states and the
// legality/alignment check applied when a request is accepted.
package lsu_pkg;

  typedef enum logic [2:0] {
    BYTE_S = 3'b000,
    HALF_S = 3'b001,
    WORD   = 3'b010,
    BYTE_U = 3'b100,
    HALF_U = 3'b101
  } access_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } state_e;

  // True when the code is legal and the byte offset suits the access size.
  function automatic logic access_ok(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl)
      BYTE_S, BYTE_U: access_ok = 1'b1;
      HALF_S, HALF_U: access_ok = ~off[0];
      WORD:           access_ok = (off == 2'b00);
      default:        access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data replication and load
// shift plus sign/zero extension.
module lsu_align (
  input  logic [1:0]  enc_size,
  input  logic [1:0]  enc_off,
  input  logic [31:0] enc_wdata_in,
  output logic [3:0]  enc_be,
  output logic [31:0] enc_wdata,
  input  logic [1:0]  dec_size,
  input  logic        dec_signed,
  input  logic [1:0]  dec_off,
  input  logic [31:0] dec_rdata_in,
  output logic [31:0] dec_rdata
);

  logic [31:0] shifted;

  always_comb begin
    enc_be    = 4'b1111;
    enc_wdata = enc_wdata_in;
    case (enc_size)
      2'b00: begin
        enc_be    = 4'b0001 << enc_off;
        enc_wdata = {4{enc_wdata_in[7:0]}};
      end
      2'b01: begin
        enc_be    = 4'b0011 << enc_off;
        enc_wdata = {2{enc_wdata_in[15:0]}};
      end
      default: begin
        enc_be    = 4'b1111;
        enc_wdata = enc_wdata_in;
      end
    endcase
  end

  always_comb begin
    shifted   = dec_rdata_in >> {dec_off, 3'b000};
    dec_rdata = shifted;
    case (dec_size)
      2'b00:   dec_rdata = {{24{dec_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   dec_rdata = {{16{dec_signed & shifted[15]}}, shifted[15:0]};
      default: dec_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory initiator: one request at a time, req/gnt/rvalid
// memory protocol. Optional gnt/rvalid timeout under LSU_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready=1, accept and check request
// ISSUE  | mem_req held with stable address/lanes until mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
// RESP   | rsp_valid pulse for one cycle
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [3:0]  enc_be;
  logic [31:0] enc_wdata;
  logic [31:0] dec_rdata;
  logic        timeout;

  lsu_align u_align (
    .enc_size     (req_ctrl[1:0]),
    .enc_off      (req_addr[1:0]),
    .enc_wdata_in (req_wdata),
    .enc_be       (enc_be),
    .enc_wdata    (enc_wdata),
    .dec_size     (ctrl_q[1:0]),
    .dec_signed   (~ctrl_q[2]),
    .dec_off      (off_q),
    .dec_rdata_in (mem_rdata),
    .dec_rdata    (dec_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive cycles in one waiting state; any state change clears it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ISSUE || state_q == WAIT_R) && state_d == state_q)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ctrl_d = req_ctrl;
          off_d  = req_addr[1:0];
          if (!access_ok(req_ctrl, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = enc_be;
            mem_wdata_d = enc_wdata;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = WAIT_R;
          end
        end else if (timeout) begin
          mem_req_d   = 1'b0;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = dec_rdata;
        end else if (timeout) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected
// responses; a negedge monitor pops and compares each rsp_valid.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp actual=rsp_valid required=no_response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
        chk("rsp_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("rsp_timeout", 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // gd: gnt stall cycles; rd: extra cycles between gnt and rvalid.
  task automatic run_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gd, input int rd,
                         input logic [31:0] rdata, input logic err, input logic [31:0] ex_rdata,
                         input logic [3:0] ex_be, input logic [31:0] ex_wdata, input logic early_rv);
    int t;
    int lat;
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    t = cyc;
    lat = err ? 1 : (we ? 2 + gd : 3 + gd + rd);
    e.err = err; e.rdata = ex_rdata; e.at = t + lat;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    if (err) begin
      for (int i = 0; i < 3; i++) begin
        chk("err_no_mem_req", 128'(mem_req), 128'(0));
        @(negedge clk);
      end
    end else begin
      for (int i = 0; i <= gd; i++) begin
        chk("mem_issue", {mem_req, mem_we, mem_addr, mem_be, mem_wdata},
            {1'b1, we, addr[31:2], 2'b00, ex_be, ex_wdata});
        chk("req_ready_busy", 128'(req_ready), 128'(0));
        if (i == gd) begin
          mem_gnt = 1'b1;
          if (early_rv) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
        end
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("mem_req_drop", 128'(mem_req), 128'(0));
      if (!we) begin
        repeat (rd) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata},
        128'(0));
    chk("reset_ready", 128'(req_ready), 128'(1));
    rst = 1'b0;
    @(negedge clk);

    // stray rvalid while idle must not produce a response
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);

    //       we    ctrl    addr          wdata         gd rd rdata         err   ex_rdata      be       wdata        early
    run_req(1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h80AB_CDEF, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0,        1'b0);
    run_req(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 0, 0, 32'h0,        1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1'b0);
    run_req(1'b0, 3'b101, 32'h0000_0300, 32'h0,        3, 0, 32'h0000_F00D, 1'b0, 32'h0000_F00D, 4'b0011, 32'h0,        1'b0);
    run_req(1'b1, 3'b010, 32'h0000_0006, 32'h5555_5555, 0, 0, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,        1'b0);
    run_req(1'b0, 3'b111, 32'h0000_0000, 32'h0,        0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,        1'b0);
    run_req(1'b0, 3'b001, 32'h0000_0041, 32'h0,        0, 0, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,        1'b0);
    run_req(1'b0, 3'b001, 32'h0000_0402, 32'h0,        0, 0, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0,        1'b0);
    run_req(1'b1, 3'b100, 32'h0000_0501, 32'h0000_00AB, 1, 0, 32'h0,        1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB, 1'b0);
    run_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0,        1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 1'b0);
    run_req(1'b0, 3'b010, 32'h0000_0020, 32'h0,        0, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 4'b1111, 32'h0,        1'b1);
    run_req(1'b0, 3'b100, 32'h0000_0602, 32'h0,        0, 0, 32'h00FF_0000, 1'b0, 32'h0000_00FF, 4'b0100, 32'h0,        1'b0);

    // reset while in WAIT_R, then a late rvalid: no response expected
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h0000_0700;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(1));
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    run_req(1'b0, 3'b010, 32'h0000_0704, 32'h0, 0, 0, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      exp_t e;
      int t;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h0000_0800;
      t = cyc;
      e.err = 1'b1; e.rdata = 32'h0; e.at = t + 17;
      sb_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (16) @(negedge clk);
      chk("timeout_mem_req", 128'(mem_req), 128'(0));
      drain();
    end
`endif

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit: the initiator side of the data-memory interface.
- Accepts one load/store request at a time from the core using a valid/ready handshake.
- Turns each request into a word-aligned, byte-enabled memory transaction with a grant handshake and a read-valid return.
- Sign- or zero-extends load data and returns a single-cycle response.
- Sits between the execute stage and the data memory, replacing direct combinational DM access.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for mem_gnt or mem_rvalid before aborting (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  3  access size/sign code (DmCtrl encoding)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bits significant
- rsp_valid  out  1  response valid, one-cycle pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal code or timeout
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request
- mem_we  out  1  memory write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Clock and reset: one clock (clk). Synchronous active-high reset (rst).
- Reset values:
  - FSM goes to IDLE.
  - rsp_valid, rsp_err, mem_req, mem_we are 0.
  - rsp_rdata, mem_addr, mem_wdata are 0.
  - mem_be is 4'b0000.
- req_ctrl codes:
  - 000 = byte signed, 001 = half signed, 010 = word.
  - 100 = byte unsigned, 101 = half unsigned.
  - 011, 110, 111 are illegal.
- FSM states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE:
  - req_ready=1 (combinational, IDLE only).
  - On req_valid&req_ready, register we/ctrl/addr/wdata.
  - Illegal code → RESP with error.
  - Half access with addr[0]=1 → RESP with error.
  - Word access with addr[1:0]≠0 → RESP with error.
  - Any error path issues no memory access.
  - Otherwise → ISSUE.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata are registered and held stable until mem_gnt.
  - On mem_gnt: a store → RESP; a load → WAIT_R.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid: shift mem_rdata right by 8*addr[1:0], extend per ctrl, store in rsp_rdata, → RESP.
  - mem_rvalid must come at least one cycle after mem_gnt; an rvalid in the same cycle as gnt is not counted.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE. rsp_err and rsp_rdata are valid only while rsp_valid=1.
- Lane rules:
  - Byte: mem_be = 4'b0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = 4'b0011<<addr[1:0]; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 4'b1111.
  - Loads drive mem_be to the same lane mask.
- Minimum latency, with request accepted at cycle T:
  - mem_req at T+1.
  - Store with gnt at T+1: rsp_valid at T+2.
  - Load with gnt at T+1 and rvalid at T+2: rsp_valid at T+3.
  - Error: rsp_valid at T+1.
- Boundaries:
  - mem_rvalid outside WAIT_R is ignored.
  - req_valid outside IDLE is not accepted (req_ready=0).
  - No response backpressure: the core must take rsp_valid when it is asserted.
- Reset mid-operation: abandon the transaction; mem_req is 0 in the cycle after rst; a late mem_rvalid is ignored; no rsp_valid is produced.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and to WAIT_R, and increments each cycle spent in them.
  - When it reaches TIMEOUT_CYCLES without gnt/rvalid: drop mem_req, → RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: no counter logic; the FSM waits forever.

Decomposition:
- Package lsu_pkg:
  - enum for the access codes (BYTE_S=3'b000, HALF_S=3'b001, WORD=3'b010, BYTE_U=3'b100, HALF_U=3'b101).
  - FSM state enum.
  - Function for the legal-code/alignment check.
- Sub-module lsu_align: combinational lane encode (be/wdata) and decode (shift plus extension), so it can be tested on its own.

Test Plan:
- Signed byte load: addr=0x0000_0103, mem_rdata=0x80AB_CDEF, gnt and rvalid with no delay → mem_addr=0x100, mem_be=4'b1000, rsp_rdata=0xFFFF_FF80, rsp_valid at T+3.
- Half store: addr=0x0000_0202, wdata=0x1234_BEEF → mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1, rsp_valid at T+2 with rsp_err=0.
- Unsigned half load with 3-cycle gnt stall, mem_rdata=0x0000_F00D, addr offset 0 → mem_req and mem_addr held stable for 4 cycles, rsp_rdata=0x0000_F00D.
- Misaligned word access at addr=0x0000_0006, plus ctrl=3'b111 → each gives rsp_err=1 at T+1, and mem_req never asserts.
- rst asserted while in WAIT_R, then a late mem_rvalid → no rsp_valid; next request accepted normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, mem_gnt tied 0 → rsp_err=1 after 16 cycles in ISSUE; mem_req then 0.
